// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the icache/dcache memory arbiter
//
// Purpose: state and requester encodings, the latched memory command record
// and a helper that names the opposite requester.
// MEM_ADDR_W / MEM_DATA_W are the widest address and data the command record
// can hold; mem_arbiter instances use widths up to these.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

  typedef struct packed {
    logic                  wen;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

  function automatic requester_e other_req(input requester_e r);
    return (r == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational two-way winner selection
//
// Purpose: picks which cache gets the memory port in an IDLE cycle.
// Ports:
//   req        in  [1:0]  request lines, bit REQ_I = icache, bit REQ_D = dcache
//   lock_vld   in  1      a burst lock is held
//   lock_owner in  1      requester holding the burst lock
//   rr_ptr     in  1      requester favoured when both ask and no lock applies
//   gnt_vld    out 1      at least one requester is asking
//   gnt        out 1      winning requester (meaningful while gnt_vld=1)
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock_vld,
  input  requester_e lock_owner,
  input  requester_e rr_ptr,
  output logic       gnt_vld,
  output requester_e gnt
);

  always_comb begin
    gnt_vld = |req;
    gnt     = rr_ptr;
    if (lock_vld && req[lock_owner]) begin
      // A lock owner that keeps asking continues its burst.
      gnt = lock_owner;
    end else if (req == 2'b01) begin
      gnt = REQ_I;
    end else if (req == 2'b10) begin
      gnt = REQ_D;
    end else begin
      gnt = rr_ptr;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word-wide memory port between icache and dcache
//
// Purpose: grants one cache at a time, registers its command onto the memory
// side, waits for mem_ready_i, then returns a one-cycle ack with read data.
// A burst lock keeps up to BURST_LEN beats from one owner contiguous; the
// round-robin pointer flips to the other cache when a burst ends or is released.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   i_req_i/i_wen_i/i_addr_i/i_wdata_i  icache request, held until i_ack_o
//   i_ack_o, i_rdata_o           icache completion pulse and read data
//   d_*                          same for dcache
//   mem_req_o/mem_wen_o/mem_addr_o/mem_wdata_o  registered memory command
//   mem_rdata_i, mem_ready_i     memory completion
//   busy_o                       a memory access is outstanding
// Optional (MEM_ARB_PERF_EN defined):
//   perf_i_beats_o, perf_d_beats_o  saturating ack counts per cache
//   perf_conflict_o                 saturating count of IDLE cycles with both requests
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic                  i_wen_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  input  logic [DATA_WIDTH-1:0] i_wdata_i,
  output logic                  i_ack_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_wen_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_wen_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  busy_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_i_beats_o,
  output logic [31:0]           perf_d_beats_o,
  output logic [31:0]           perf_conflict_o
`endif
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_e       state_q, state_d;
  mem_cmd_t         cmd_q, cmd_d;
  requester_e       owner_q, owner_d;
  logic             lock_vld_q, lock_vld_d;
  requester_e       lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  requester_e       rr_ptr_q, rr_ptr_d;

  logic [1:0]       req;
  logic             gnt_vld;
  requester_e       gnt;
  mem_cmd_t         i_cmd, d_cmd;
  logic             beat_done;

  assign req = {d_req_i, i_req_i};

  rr_picker u_rr_picker (
    .req        (req),
    .lock_vld   (lock_vld_q),
    .lock_owner (lock_owner_q),
    .rr_ptr     (rr_ptr_q),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  always_comb begin
    i_cmd.wen   = i_wen_i;
    i_cmd.addr  = MEM_ADDR_W'(i_addr_i);
    i_cmd.wdata = MEM_DATA_W'(i_wdata_i);
    d_cmd.wen   = d_wen_i;
    d_cmd.addr  = MEM_ADDR_W'(d_addr_i);
    d_cmd.wdata = MEM_DATA_W'(d_wdata_i);
  end

  // Next-state and datapath latching.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    owner_d      = owner_q;
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    beat_cnt_d   = beat_cnt_q;
    rr_ptr_d     = rr_ptr_q;

    case (state_q)
      IDLE: begin
        // Owner stopped asking: give up the lock and favour the other cache.
        if (lock_vld_q && !req[lock_owner_q]) begin
          lock_vld_d = 1'b0;
          rr_ptr_d   = other_req(lock_owner_q);
        end
        if (gnt_vld) begin
          state_d = BUSY;
          owner_d = gnt;
          cmd_d   = (gnt == REQ_D) ? d_cmd : i_cmd;
          // A new owner starts a fresh burst; this overrides a release made
          // in the same cycle so the newcomer holds the lock.
          if (!lock_vld_q || (lock_owner_q != gnt)) begin
            lock_vld_d   = 1'b1;
            lock_owner_d = gnt;
            beat_cnt_d   = '0;
          end
        end
      end

      BUSY: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          if (beat_cnt_q == LAST_BEAT) begin
            lock_vld_d = 1'b0;
            beat_cnt_d = '0;
            rr_ptr_d   = other_req(owner_q);
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      owner_q      <= REQ_I;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= REQ_I;
      beat_cnt_q   <= '0;
      rr_ptr_q     <= REQ_D;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      owner_q      <= owner_d;
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // mem_req_o comes straight from the state flop so an async reset drops it
  // without waiting for a clock edge.
  assign busy_o      = (state_q == BUSY);
  assign mem_req_o   = (state_q == BUSY);
  assign mem_wen_o   = cmd_q.wen;
  assign mem_addr_o  = ADDR_WIDTH'(cmd_q.addr);
  assign mem_wdata_o = DATA_WIDTH'(cmd_q.wdata);

  assign beat_done = (state_q == BUSY) && mem_ready_i;
  assign i_ack_o   = beat_done && (owner_q == REQ_I);
  assign d_ack_o   = beat_done && (owner_q == REQ_D);
  assign i_rdata_o = i_ack_o ? mem_rdata_i : '0;
  assign d_rdata_o = d_ack_o ? mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_d_q, perf_c_q;
  logic        conflict;

  assign conflict = (state_q == IDLE) && i_req_i && d_req_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      if (i_ack_o && (perf_i_q != '1)) perf_i_q <= perf_i_q + 32'd1;
      if (d_ack_o && (perf_d_q != '1)) perf_d_q <= perf_d_q + 32'd1;
      if (conflict && (perf_c_q != '1)) perf_c_q <= perf_c_q + 32'd1;
    end
  end

  assign perf_i_beats_o  = perf_i_q;
  assign perf_d_beats_o  = perf_d_q;
  assign perf_conflict_o = perf_c_q;
`endif

endmodule
